fetch_pc_gen: RTL
=================

Name: fetch_pc_gen

Overview:
- Front end of the fetch stage: owns the program counter and issues instruction-memory reads over a valid/ready request plus valid response handshake.
- Drives the instruction/pc/nop inputs of the IF/ID pipeline register, which captures them on the falling edge of clk.
- Handles stall (hold), redirect (branch/jump target) and bubble insertion.
- At most one memory request is outstanding at any time.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- PC_STEP, 4, increment applied after each consumed instruction.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  downstream cannot accept; hold the presented instruction.
- redirect_valid  in  1  load redirect_pc as next fetch PC; squash in-flight work.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req_valid  out  1  read request valid.
- imem_req_addr  out  32  read address.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_resp_valid  in  1  read data valid.
- imem_resp_data  in  32  instruction word.
- instruction  out  32  to IF/ID input_instruction.
- pc_out  out  32  to IF/ID pc_in; PC of instruction.
- nop_output  out  1  high when instruction/pc_out do not hold a valid instruction.

Behaviour:
- Registers: state, pc (next fetch address), instruction, pc_out, valid. nop_output = !valid. imem_req_addr = pc. imem_req_valid = (state==REQ).
- Reset (async): state=REQ, pc=RESET_PC, instruction=`NOP_INSTRUCTION (32'h0000_0013), pc_out=0, valid=0. So nop_output=1 and imem_req_valid=1 from reset.
- States:
  - REQ: when imem_req_ready=1, go to WAIT.
  - WAIT: on imem_resp_valid, either
    - load instruction=imem_resp_data, pc_out=pc, valid=1, pc=pc+PC_STEP; go to REQ if stall=0, else HOLD; or
    - if valid=1 and stall=1 (previous instruction not yet consumed), go to HOLD_RESP.
  - HOLD: valid=1, no request. When stall=0, go to REQ.
  - HOLD_RESP: holds a buffered word in a skid register. When stall=0, move the skid word into instruction/pc_out and go to REQ.
  - DRAIN: a redirect arrived while a response was owed. Discard the next imem_resp_valid, then go to REQ.
- Consumption: valid clears on any posedge with valid=1 and stall=0, unless a new word loads in the same cycle.
- Redirect (highest priority, same posedge):
  - pc=redirect_pc&~3; valid=0; instruction=`NOP_INSTRUCTION; any skid word dropped.
  - From WAIT: go to DRAIN if imem_resp_valid=0 that cycle; go to REQ if it is 1 (the word is discarded).
  - From REQ, HOLD or HOLD_RESP: go to REQ. A REQ handshake completing in the same cycle as a redirect goes to DRAIN.
  - Redirect overrides stall.
- Latency: zero-wait memory gives request at cycle N, response at N+1, valid=1 from N+2. Throughput is one instruction per 2 cycles.
- pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Responses arriving in REQ, HOLD or HOLD_RESP are protocol errors and are ignored.
- Reset mid-transaction returns the block to the reset state; the memory is assumed reset by the same rst.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs fetched_count[31:0] and bubble_count[31:0], both reset to 0.
  - fetched_count increments on every word loaded into instruction.
  - bubble_count increments every cycle nop_output=1 and stall=0.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory always ready, 1-cycle response returning 32'h00A00093 at address 0 -> imem_req_addr=0x0. Two cycles later instruction=0x00A00093, pc_out=0x0, nop_output=0. Next request address is 0x4.
- stall=1 for 5 cycles while valid -> instruction and pc_out frozen, no extra request while HOLD. After release, next request address is 0x8.
- redirect_valid=1, redirect_pc=0x103 while in WAIT -> nop_output=1 next cycle. The pending response is discarded, the next request goes to 0x100, and the first valid pc_out is 0x100.
- stall=1 while a second response arrives -> the word goes to HOLD_RESP. On stall release it is presented with pc_out=prior+4, with no word lost or duplicated.
- imem_req_ready low for 3 cycles -> imem_req_valid and imem_req_addr stay stable until accepted.
- redirect_pc=0xFFFF_FFFC -> pc_out=0xFFFF_FFFC, then next request address 0x0. With FETCH_PERF_CNT_EN defined, fetched_count equals the number of presented words.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-stage front end. Owns the program counter, issues
// single-outstanding instruction-memory reads (valid/ready request, valid
// response) and presents instruction/pc/nop to the IF/ID register.
// Handles stall (hold), redirect (squash + new target) and a one-word skid
// buffer for a response that arrives while the presented word is stalled.
// Optional build macro: FETCH_PERF_CNT_EN adds fetched/bubble counters.

`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        nop_output
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetched_count,
  output logic [31:0] bubble_count
`endif
);

  localparam logic [31:0] NOP_INSTR = `NOP_INSTRUCTION;

  localparam logic [2:0] ST_REQ       = 3'd0;
  localparam logic [2:0] ST_WAIT      = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_HOLD_RESP = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  logic [2:0]  state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        valid_r, valid_s;
  logic [31:0] skid_data_r, skid_data_s;
  logic [31:0] skid_pc_r, skid_pc_s;
  logic [31:0] instr_s;
  logic [31:0] pc_out_s;
  logic        load_s;

  assign imem_req_valid = (state_r == ST_REQ);
  assign imem_req_addr  = pc_r;
  assign nop_output     = ~valid_r;

  // Next-state and datapath decode; redirect takes priority over everything.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    valid_s     = valid_r;
    skid_data_s = skid_data_r;
    skid_pc_s   = skid_pc_r;
    instr_s     = instruction;
    pc_out_s    = pc_out;
    load_s      = 1'b0;
    if (redirect_valid) begin
      pc_s    = redirect_pc & 32'hFFFF_FFFC;
      valid_s = 1'b0;
      instr_s = NOP_INSTR;
      case (state_r)
        // A response is still owed: drop it now if it is here, else drain it.
        ST_WAIT, ST_DRAIN: begin
          if (imem_resp_valid) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        // A request accepted this cycle will produce a stale response.
        ST_REQ: begin
          if (imem_req_ready) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_REQ;
          end
        end
        default: state_s = ST_REQ;
      endcase
    end else begin
      // Downstream consumes the presented word whenever it is not stalled.
      if (valid_r && !stall) begin
        valid_s = 1'b0;
      end else begin
        valid_s = valid_r;
      end
      case (state_r)
        ST_REQ: begin
          if (imem_req_ready) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            pc_s = pc_r + PC_STEP;
            if (valid_r && stall) begin
              // Presented word still occupied: park the new one in the skid.
              skid_data_s = imem_resp_data;
              skid_pc_s   = pc_r;
              state_s     = ST_HOLD_RESP;
            end else begin
              instr_s  = imem_resp_data;
              pc_out_s = pc_r;
              valid_s  = 1'b1;
              load_s   = 1'b1;
              if (stall) begin
                state_s = ST_HOLD;
              end else begin
                state_s = ST_REQ;
              end
            end
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_HOLD_RESP: begin
          if (!stall) begin
            instr_s  = skid_data_r;
            pc_out_s = skid_pc_r;
            valid_s  = 1'b1;
            load_s   = 1'b1;
            state_s  = ST_REQ;
          end else begin
            state_s = ST_HOLD_RESP;
          end
        end
        ST_DRAIN: begin
          if (imem_resp_valid) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        default: state_s = ST_REQ;
      endcase
    end
  end

  // State, PC, skid buffer and IF/ID-facing output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_REQ;
      pc_r        <= RESET_PC;
      valid_r     <= 1'b0;
      skid_data_r <= 32'h0000_0000;
      skid_pc_r   <= 32'h0000_0000;
      instruction <= NOP_INSTR;
      pc_out      <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      valid_r     <= valid_s;
      skid_data_r <= skid_data_s;
      skid_pc_r   <= skid_pc_s;
      instruction <= instr_s;
      pc_out      <= pc_out_s;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: words loaded for presentation, and idle unstalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_count <= 32'h0000_0000;
      bubble_count  <= 32'h0000_0000;
    end else begin
      if (load_s) begin
        fetched_count <= fetched_count + 32'h0000_0001;
      end else begin
        fetched_count <= fetched_count;
      end
      if (!valid_r && !stall) begin
        bubble_count <= bubble_count + 32'h0000_0001;
      end else begin
        bubble_count <= bubble_count;
      end
    end
  end
`endif

endmodule
